// File: rtl/fixed_lat_sched_if.sv
// Requester/resource bundle for the fixed-latency scheduler.
// The scheduler takes the slave view. The requester/resource side takes the master view.
interface fixed_lat_sched_if #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 3,
  parameter int ERR_W   = 8
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             issue;
  logic [ID_W-1:0]  issue_id;
  logic             res_rsp;
  logic [N_REQ-1:0] done;
  logic             err_miss;
  logic             err_spur;
  logic [OUT_W-1:0] outstanding;
  logic [ERR_W-1:0] err_cnt;

  modport slave (
    input  en, req, res_rsp,
    output gnt, issue, issue_id, done, err_miss, err_spur, outstanding, err_cnt
  );

  modport master (
    output en, req, res_rsp,
    input  gnt, issue, issue_id, done, err_miss, err_spur, outstanding, err_cnt
  );
endinterface

// File: rtl/fixed_lat_sched.sv
// Round-robin scheduler for a fixed-latency pipelined resource.
// A response is required exactly LAT edges after each issue; missing and spurious responses are counted.
module fixed_lat_sched #(
  parameter int N_REQ   = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 3,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fixed_lat_sched_if.slave  bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [LAT-1:0]   vld_q, vld_d;
  logic [ID_W-1:0]  id_q [LAT];
  logic [ID_W-1:0]  id_d [LAT];
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_miss_q, err_miss_d;
  logic             err_spur_q, err_spur_d;

  logic             exp_s;
  logic [ID_W-1:0]  exp_id_s;
  logic             elig_s;
  logic             found_s;
  logic [ID_W-1:0]  win_s;
  logic [ID_W:0]    cand_s;
  logic [N_REQ-1:0] gnt_s;

  assign exp_s    = vld_q[LAT-1];
  assign exp_id_s = id_q[LAT-1];

  // Round-robin search from the pointer, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && bus.req[cand_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // At the cap, a slot is free only when an entry is retiring on this same edge.
  always_comb begin
    elig_s = bus.en & found_s &
             ((out_q < MAX_OUT_V) | ((out_q == MAX_OUT_V) & exp_s));
    if (elig_s) begin
      gnt_s = ONE_HOT0 << win_s;
    end else begin
      gnt_s = '0;
    end
  end

  assign bus.gnt         = gnt_s;
  assign bus.issue       = |gnt_s;
  assign bus.issue_id    = win_s;
  assign bus.done        = done_q;
  assign bus.err_miss    = err_miss_q;
  assign bus.err_spur    = err_spur_q;
  assign bus.outstanding = out_q;
  assign bus.err_cnt     = err_cnt_q;

  // Next state: tag pipeline shift, pointer, in-flight count, response check.
  always_comb begin
    vld_d = '0;
    for (int i = 0; i < LAT; i++) begin
      id_d[i] = '0;
    end
    vld_d[0] = elig_s;
    id_d[0]  = win_s;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end

    if (elig_s) begin
      if (win_s == ID_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + ID_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end

    case ({elig_s, exp_s})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase

    if (exp_s && bus.res_rsp) begin
      done_d = ONE_HOT0 << exp_id_s;
    end else begin
      done_d = '0;
    end
    err_miss_d = exp_s & ~bus.res_rsp;
    err_spur_d = ~exp_s & bus.res_rsp;

    if ((err_miss_d || err_spur_d) && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers; reset discards in-flight entries without reporting them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      for (int i = 0; i < LAT; i++) begin
        id_q[i] <= '0;
      end
      ptr_q      <= '0;
      out_q      <= '0;
      err_cnt_q  <= '0;
      done_q     <= '0;
      err_miss_q <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      for (int i = 0; i < LAT; i++) begin
        id_q[i] <= id_d[i];
      end
      ptr_q      <= ptr_d;
      out_q      <= out_d;
      err_cnt_q  <= err_cnt_d;
      done_q     <= done_d;
      err_miss_q <= err_miss_d;
      err_spur_q <= err_spur_d;
    end
  end
endmodule

// File: tb/tb_fixed_lat_sched.sv
// Bench for fixed_lat_sched: directed scenarios plus a random phase against a per-edge issue-history model.
// A second instance (MAX_OUT=1, ERR_W=2) covers issue spacing and counter saturation.
module tb_fixed_lat_sched;
  localparam int N    = 4;
  localparam int LAT  = 3;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_lat_sched_if #(.N_REQ(4), .MAX_OUT(3), .ERR_W(8)) bif ();
  fixed_lat_sched_if #(.N_REQ(4), .MAX_OUT(1), .ERR_W(2)) bif_b ();

  fixed_lat_sched #(.N_REQ(4), .LAT(3), .MAX_OUT(3), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif));
  fixed_lat_sched #(.N_REQ(4), .LAT(3), .MAX_OUT(1), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bif_b));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: hist[k] is the requester issued at edge k, or -1.
  int hist [0:4095];
  int cyc;
  int m_ptr;
  int m_err;
  int last_win;
  int gnt_log [$];
  int done_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int m_out();
    int n = 0;
    for (int k = cyc - LAT; k < cyc; k++) begin
      if (hist[k] >= 0) n++;
    end
    return n;
  endfunction

  function automatic logic m_exp();
    return hist[cyc - LAT] >= 0;
  endfunction

  function automatic int m_winner(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4096; k++) hist[k] = -1;
    cyc   = LAT + 1;
    m_ptr = 0;
    m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.en = 1'b0; bif.req = 4'b0; bif.res_rsp = 1'b0;
    bif_b.en = 1'b0; bif_b.req = 4'b0; bif_b.res_rsp = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_outstanding", 32'(bif.outstanding), 32'd0);
    chk("rst_err_cnt", 32'(bif.err_cnt), 32'd0);
    chk("rst_err_flags", {30'd0, bif.err_miss, bif.err_spur}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic en_i, input logic [3:0] req_i, input logic rsp_i);
    int w;
    int eid;
    int o;
    logic ex;
    logic elig;
    @(negedge clk);
    bif.en = en_i; bif.req = req_i; bif.res_rsp = rsp_i;
    #1;
    o    = m_out();
    ex   = m_exp();
    eid  = hist[cyc - LAT];
    elig = en_i && (req_i != 4'b0) && ((o < MAXO) || ((o == MAXO) && ex));
    w    = elig ? m_winner(req_i) : -1;
    chk("gnt", 32'(bif.gnt), elig ? (32'd1 << w) : 32'd0);
    chk("issue", 32'(bif.issue), 32'(elig));
    if (elig) chk("issue_id", 32'(bif.issue_id), 32'(w));
    last_win = w;
    if (w >= 0) gnt_log.push_back(w);
    @(posedge clk);
    hist[cyc] = w;
    if (w >= 0) m_ptr = (w + 1) % N;
    cyc++;
    if (ex != rsp_i && m_err < 255) m_err++;
    #1;
    chk("done", 32'(bif.done), (ex && rsp_i) ? (32'd1 << eid) : 32'd0);
    if (ex && rsp_i) done_log.push_back(eid);
    chk("err_miss", 32'(bif.err_miss), 32'(ex && !rsp_i));
    chk("err_spur", 32'(bif.err_spur), 32'(!ex && rsp_i));
    chk("outstanding", 32'(bif.outstanding), 32'(m_out()));
    chk("err_cnt", 32'(bif.err_cnt), 32'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rq;
    logic en_r;
    logic rsp_r;
    int peak;
    bit issued_b [0:31];
    int iss_cyc [$];

    bif.en = 1'b0; bif.req = 4'b0; bif.res_rsp = 1'b0;
    bif_b.en = 1'b0; bif_b.req = 4'b0; bif_b.res_rsp = 1'b0;
    model_reset();

    // Single requester, response on time.
    do_reset();
    step(1'b1, 4'b0001, 1'b0);
    chk("t1_out_after_issue", 32'(bif.outstanding), 32'd1);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    chk("t1_done0", 32'(bif.done), 32'h1);
    chk("t1_out_after_retire", 32'(bif.outstanding), 32'd0);

    // Late response: miss then spurious.
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    chk("t2_miss", 32'(bif.err_miss), 32'd1);
    step(1'b1, 4'b0000, 1'b1);
    chk("t2_spur", 32'(bif.err_spur), 32'd1);
    chk("t2_err_cnt", 32'(bif.err_cnt), 32'd2);

    // All requesters, full throughput.
    do_reset();
    gnt_log.delete(); done_log.delete(); peak = 0;
    for (int i = 0; i < 8 + LAT; i++) begin
      step(1'b1, (i < 8) ? 4'hF : 4'h0, m_exp());
      if (int'(bif.outstanding) > peak) peak = int'(bif.outstanding);
    end
    chk("t3_n_issue", 32'(gnt_log.size()), 32'd8);
    chk("t3_n_done", 32'(done_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < gnt_log.size() && i < done_log.size(); i++) begin
      chk("t3_gnt_order", 32'(gnt_log[i]), 32'(i % 4));
      chk("t3_done_order", 32'(done_log[i]), 32'(i % 4));
    end
    chk("t3_peak_out", 32'(peak), 32'd3);

    // en dropped after two issues; in-flight work still completes.
    do_reset();
    gnt_log.delete(); done_log.delete();
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'hF, m_exp());
    step(1'b1, 4'hF, 1'b0);
    chk("t4_n_issue", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() == 3) chk("t4_resume_id", 32'(gnt_log[2]), 32'd2);
    chk("t4_n_done", 32'(done_log.size()), 32'd2);

    // Reset with two in flight, then a stale response.
    do_reset();
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    do_reset();
    step(1'b0, 4'h0, 1'b1);
    chk("t5_spur", 32'(bif.err_spur), 32'd1);
    chk("t5_done", 32'(bif.done), 32'd0);
    chk("t5_err_cnt", 32'(bif.err_cnt), 32'd1);

    // Random phase: sticky requests, random enable, occasional bad responses.
    do_reset();
    rq = 4'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        do_reset();
        rq = 4'b0;
      end
      if ($urandom_range(0, 2) == 0) rq = rq | 4'($urandom_range(0, 15));
      en_r  = ($urandom_range(0, 7) != 0);
      rsp_r = m_exp() ^ ($urandom_range(0, 11) == 0);
      step(en_r, rq, rsp_r);
      if (last_win >= 0) rq[last_win] = 1'b0;
    end

    // Second instance: MAX_OUT=1 spacing, then ERR_W=2 saturation.
    do_reset();
    for (int k = 0; k < 32; k++) issued_b[k] = 1'b0;
    iss_cyc.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bif_b.en = 1'b1;
      bif_b.req = (c < 13) ? 4'b0010 : 4'b0000;
      bif_b.res_rsp = (c >= 3) ? issued_b[c-3] : 1'b0;
      #1;
      if (bif_b.issue) begin
        issued_b[c] = 1'b1;
        iss_cyc.push_back(c);
        chk("b_issue_id", 32'(bif_b.issue_id), 32'd1);
      end
      @(posedge clk);
    end
    #1;
    chk("b_n_issue", 32'(iss_cyc.size()), 32'd5);
    if (iss_cyc.size() > 0) chk("b_first_issue", 32'(iss_cyc[0]), 32'd0);
    for (int k = 1; k < iss_cyc.size(); k++) begin
      chk("b_spacing", 32'(iss_cyc[k] - iss_cyc[k-1]), 32'd3);
    end
    chk("b_err_clean", 32'(bif_b.err_cnt), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bif_b.req = 4'b0;
      bif_b.res_rsp = 1'b1;
      @(posedge clk);
      #1;
      chk("b_spur", 32'(bif_b.err_spur), 32'd1);
      chk("b_err_sat", 32'(bif_b.err_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    @(negedge clk);
    bif_b.res_rsp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
